// File: rtl/vbr_pkg.sv
// -----------------------------------------------------------------------------
// vbr_pkg
// Shared types and constants for the vertex buffer reader.
//   vbr_state_t  : frame sequencing states
//   vbr_record_t : one 224-bit triangle record
//   field constants give the bit positions of flags and the x1/x2/x3 coords
//   TERMINATOR   : end-of-frame marker pushed after the last record
// -----------------------------------------------------------------------------
package vbr_pkg;

    localparam int REC_W = 224;
    localparam int X_W   = 12;

    typedef logic [REC_W-1:0] vbr_record_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_EOF    = 3'd4,
        ST_DONE   = 3'd5
    } vbr_state_t;

    localparam int FLAGS_HI = 223;
    localparam int FLAGS_LO = 216;
    localparam int X1_HI    = 215;
    localparam int X1_LO    = 204;
    localparam int X2_HI    = 203;
    localparam int X2_LO    = 192;
    localparam int X3_HI    = 191;
    localparam int X3_LO    = 180;

    localparam vbr_record_t TERMINATOR = {1'b1, {(REC_W-1){1'b0}}};

endpackage

// File: rtl/vbr_degenerate_detect.sv
// -----------------------------------------------------------------------------
// vbr_degenerate_detect
// Flags a triangle whose three x coordinates coincide (zero-area in x).
//   i_x1, i_x2, i_x3 : the x coordinates of the record
//   o_degenerate     : 1 when x1 == x2 == x3 (purely combinational)
// -----------------------------------------------------------------------------
module vbr_degenerate_detect
    import vbr_pkg::*;
(
    input  logic [X_W-1:0] i_x1,
    input  logic [X_W-1:0] i_x2,
    input  logic [X_W-1:0] i_x3,
    output logic           o_degenerate
);

    assign o_degenerate = (i_x1 == i_x2) && (i_x2 == i_x3);

endmodule

// File: rtl/vertex_buffer_reader.sv
// -----------------------------------------------------------------------------
// vertex_buffer_reader
// Drains the show-ahead vertex buffer into the triangle FIFO once per frame,
// forwarding at most MAX_TRIS records and closing the frame with a terminator.
//
// Ports
//   clk100                          : clock, all logic on rising edge
//   rst_n                           : synchronous active-low reset
//   nextFrame                       : one-cycle pulse, (re)starts a frame
//   VertexBuffer_PreCalc_empty      : source empty, lags pop by 2 cycles
//   VertexBuffer_PreCalc_ReadData   : source head record (show-ahead)
//   VertexBuffer_PreCalc_pop        : registered pulse advancing the source
//   PreCalc_TriangleFIFO_wait       : sink back-pressure
//   PreCalc_TriangleFIFO_push       : registered write strobe
//   PreCalc_TriangleFIFO_WriteData  : registered write data
//   tri_count                       : records pushed this frame (saturating)
//   busy                            : high outside IDLE and DONE
//
// Build option
//   VBR_DEGENERATE_CULL_EN : when defined, records with x1==x2==x3 are popped
//                            but not pushed and not counted.
// -----------------------------------------------------------------------------
module vertex_buffer_reader
    import vbr_pkg::*;
#(
    parameter logic [7:0] MAX_TRIS = 8'd108
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic              nextFrame,
    input  logic              VertexBuffer_PreCalc_empty,
    input  logic [REC_W-1:0]  VertexBuffer_PreCalc_ReadData,
    output logic              VertexBuffer_PreCalc_pop,
    input  logic              PreCalc_TriangleFIFO_wait,
    output logic              PreCalc_TriangleFIFO_push,
    output logic [REC_W-1:0]  PreCalc_TriangleFIFO_WriteData,
    output logic [7:0]        tri_count,
    output logic              busy
);

    vbr_state_t  r_state;
    logic        r_push;
    logic        r_pop;
    vbr_record_t r_wdata;
    logic [7:0]  r_tri_count;

    vbr_state_t  w_next_state;
    logic        w_push_d;
    logic        w_pop_d;
    logic        w_load_rec;
    logic        w_load_term;
    logic        w_count_inc;
    logic        w_count_clr;
    logic        w_degenerate;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        if (c >= MAX_TRIS) begin
            return MAX_TRIS;
        end
        return c + 8'd1;
    endfunction

    // The captured record sits in r_wdata during ISSUE, so the cull decision
    // is taken on exactly the record that would be pushed.
`ifdef VBR_DEGENERATE_CULL_EN
    vbr_degenerate_detect u_degenerate_detect (
        .i_x1         (r_wdata[X1_HI:X1_LO]),
        .i_x2         (r_wdata[X2_HI:X2_LO]),
        .i_x3         (r_wdata[X3_HI:X3_LO]),
        .o_degenerate (w_degenerate)
    );
`else
    assign w_degenerate = 1'b0;
`endif

    // Next-state and registered-output decode
    always_comb begin
        w_next_state = r_state;
        w_push_d     = 1'b0;
        w_pop_d      = 1'b0;
        w_load_rec   = 1'b0;
        w_load_term  = 1'b0;
        w_count_inc  = 1'b0;
        w_count_clr  = 1'b0;

        if (nextFrame) begin
            // A new frame wins over anything in flight, including an ISSUE
            // whose push/pop would otherwise be committed on this edge.
            w_next_state = ST_FETCH;
            w_count_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_IDLE;
                end
                ST_FETCH: begin
                    if (r_tri_count == MAX_TRIS) begin
                        w_next_state = ST_EOF;
                    end else if (VertexBuffer_PreCalc_empty) begin
                        w_next_state = ST_EOF;
                    end else if (!PreCalc_TriangleFIFO_wait) begin
                        w_load_rec   = 1'b1;
                        w_next_state = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Committed in FETCH; wait is deliberately ignored here.
                    w_pop_d      = 1'b1;
                    w_next_state = ST_SETTLE;
                    if (!w_degenerate) begin
                        w_push_d    = 1'b1;
                        w_count_inc = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // One spare cycle so the source's registered empty and
                    // new head reflect the pop before FETCH looks at them.
                    w_next_state = ST_FETCH;
                end
                ST_EOF: begin
                    if (!PreCalc_TriangleFIFO_wait) begin
                        w_push_d     = 1'b1;
                        w_load_term  = 1'b1;
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_next_state = ST_DONE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_wdata     <= '0;
            r_tri_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_push  <= w_push_d;
            r_pop   <= w_pop_d;
            if (w_load_rec) begin
                r_wdata <= VertexBuffer_PreCalc_ReadData;
            end else if (w_load_term) begin
                r_wdata <= TERMINATOR;
            end
            if (w_count_clr) begin
                r_tri_count <= '0;
            end else if (w_count_inc) begin
                r_tri_count <= sat_inc(r_tri_count);
            end
        end
    end

    assign VertexBuffer_PreCalc_pop       = r_pop;
    assign PreCalc_TriangleFIFO_push      = r_push;
    assign PreCalc_TriangleFIFO_WriteData = r_wdata;
    assign tri_count                      = r_tri_count;
    assign busy                           = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_vertex_buffer_reader.sv
// -----------------------------------------------------------------------------
// tb_vertex_buffer_reader
// Self-checking bench: a show-ahead source model with registered empty, a
// monitor logging every push, and a frame-level reference model of which
// records reach the FIFO.
// -----------------------------------------------------------------------------
module tb_vertex_buffer_reader;

    localparam int MAXT = 108;
    localparam logic [223:0] TERM = {1'b1, 223'b0};

    logic         clk100 = 1'b0;
    logic         rst_n;
    logic         nextFrame;
    logic         fifo_wait;
    logic [223:0] rdata;
    logic         pop;
    logic         push;
    logic [223:0] wdata;
    logic [7:0]   tri_count;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk100 = ~clk100;

    // Source model: show-ahead head, empty registered at the source
    logic [223:0] src_mem [0:255];
    int   src_n     = 0;
    int   src_head  = 0;
    logic src_rst   = 1'b0;
    logic src_empty = 1'b1;

    assign rdata = (src_head < src_n) ? src_mem[src_head[7:0]] : '0;

    always @(posedge clk100) begin
        if (src_rst) begin
            src_head  <= 0;
            src_empty <= (src_n == 0);
        end else if (pop && src_head < src_n) begin
            src_head  <= src_head + 1;
            src_empty <= (src_head + 1 >= src_n);
        end
    end

    vertex_buffer_reader #(.MAX_TRIS(8'(MAXT))) dut (
        .clk100                         (clk100),
        .rst_n                          (rst_n),
        .nextFrame                      (nextFrame),
        .VertexBuffer_PreCalc_empty     (src_empty),
        .VertexBuffer_PreCalc_ReadData  (rdata),
        .VertexBuffer_PreCalc_pop       (pop),
        .PreCalc_TriangleFIFO_wait      (fifo_wait),
        .PreCalc_TriangleFIFO_push      (push),
        .PreCalc_TriangleFIFO_WriteData (wdata),
        .tri_count                      (tri_count),
        .busy                           (busy)
    );

    // Monitor: cycle counter and push/pop log sampled on the falling edge
    int           cyc = 0;
    logic [223:0] mon_data [$];
    int           mon_cyc  [$];
    int           mon_pops = 0;

    always @(posedge clk100) cyc <= cyc + 1;

    always @(negedge clk100) begin
        if (push) begin
            mon_data.push_back(wdata);
            mon_cyc.push_back(cyc);
        end
        if (pop) mon_pops = mon_pops + 1;
    end

    // Reference model: which records a frame forwards, and how many it pops
    logic [223:0] exp_q [$];
    int           exp_pops;
    int           exp_count;

    function automatic bit cull_on();
`ifdef VBR_DEGENERATE_CULL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_degen(input logic [223:0] r);
        return (r[215:204] == r[203:192]) && (r[203:192] == r[191:180]);
    endfunction

    task automatic build_model(input int first);
        exp_q.delete();
        exp_pops  = 0;
        exp_count = 0;
        for (int i = first; i < src_n && exp_count < MAXT; i++) begin
            exp_pops++;
            if (!(cull_on() && is_degen(src_mem[i]))) begin
                exp_q.push_back(src_mem[i]);
                exp_count++;
            end
        end
        exp_q.push_back(TERM);
    endtask

    function automatic logic [223:0] rand_rec();
        logic [223:0] r;
        for (int w = 0; w < 7; w++) r[w*32 +: 32] = $urandom;
        if (r[215:204] == r[203:192]) r[192] = ~r[192];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic load_src(input int n);
        src_n = n;
        for (int i = 0; i < n; i++) src_mem[i] = rand_rec();
        src_rst = 1'b1;
        tick();
        src_rst = 1'b0;
    endtask

    task automatic pulse_frame(output int c0);
        nextFrame = 1'b1;
        tick();
        nextFrame = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; nextFrame = 1'b1; fifo_wait = 1'b0;
        tick(); tick();
        nextFrame = 1'b0;
        n_checks++; if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push got=%b want=0", push); end
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b want=0", pop); end
        n_checks++; if (wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h want=0", wdata); end
        n_checks++; if (tri_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", tri_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic_frame();
        int base, pops0, c0, got;
        bit ok;
        load_src(3);
        fifo_wait = 1'b0;
        base = mon_data.size(); pops0 = mon_pops;
        pulse_frame(c0);
        wait_idle(100, ok);
        build_model(0);
        got = mon_data.size() - base;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout busy=%b want=0", busy); end
        n_checks++; if (got != exp_q.size()) begin n_fail++; $display("FAIL basic_npush got=%0d want=%0d", got, exp_q.size()); end
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            n_checks++;
            if (mon_data[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_data[%0d] got=%h want=%h", i, mon_data[base+i], exp_q[i]); end
        end
        if (got >= 3) begin
            n_checks++; if (mon_cyc[base] != c0 + 2) begin n_fail++; $display("FAIL basic_first_cyc got=%0d want=%0d", mon_cyc[base], c0 + 2); end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (mon_cyc[base+i] - mon_cyc[base+i-1] != 3) begin n_fail++; $display("FAIL basic_spacing[%0d] got=%0d want=3", i, mon_cyc[base+i] - mon_cyc[base+i-1]); end
            end
        end
        if (got >= 1) begin
            n_checks++; if (mon_data[base+got-1] !== TERM) begin n_fail++; $display("FAIL basic_term got=%h want=%h", mon_data[base+got-1], TERM); end
        end
        n_checks++; if (tri_count !== 8'd3) begin n_fail++; $display("FAIL basic_count got=%0d want=3", tri_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got=%b want=0", busy); end
        n_checks++; if (mon_pops - pops0 != 3) begin n_fail++; $display("FAIL basic_pops got=%0d want=3", mon_pops - pops0); end
        base = mon_data.size();
        repeat (6) tick();
        n_checks++; if (mon_data.size() != base) begin n_fail++; $display("FAIL done_hold got=%0d want=0 extra pushes", mon_data.size() - base); end
    endtask

    task automatic test_wait_backpressure();
        int base, pops0, c0, w, got;
        bit ok;
        load_src(2);
        fifo_wait = 1'b1;
        base = mon_data.size(); pops0 = mon_pops;
        pulse_frame(c0);
        repeat (10) tick();
        n_checks++; if (mon_data.size() != base) begin n_fail++; $display("FAIL wait_push got=%0d want=0", mon_data.size() - base); end
        n_checks++; if (mon_pops != pops0) begin n_fail++; $display("FAIL wait_pop got=%0d want=0", mon_pops - pops0); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy got=%b want=1", busy); end
        fifo_wait = 1'b0;
        w = cyc;
        wait_idle(100, ok);
        build_model(0);
        got = mon_data.size() - base;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wait_timeout busy=%b want=0", busy); end
        n_checks++; if (got != exp_q.size()) begin n_fail++; $display("FAIL wait_npush got=%0d want=%0d", got, exp_q.size()); end
        if (got >= 1) begin
            n_checks++; if (mon_cyc[base] != w + 2) begin n_fail++; $display("FAIL wait_first_cyc got=%0d want=%0d", mon_cyc[base], w + 2); end
            n_checks++; if (mon_data[base] !== exp_q[0]) begin n_fail++; $display("FAIL wait_data got=%h want=%h", mon_data[base], exp_q[0]); end
        end
        n_checks++; if (tri_count !== 8'(exp_count)) begin n_fail++; $display("FAIL wait_count got=%0d want=%0d", tri_count, exp_count); end
    endtask

    task automatic test_max_tris();
        int base, pops0, c0, got, bad;
        bit ok;
        load_src(200);
        fifo_wait = 1'b0;
        base = mon_data.size(); pops0 = mon_pops;
        pulse_frame(c0);
        wait_idle(2000, ok);
        build_model(0);
        got = mon_data.size() - base;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL max_timeout busy=%b want=0", busy); end
        n_checks++; if (got != MAXT + 1) begin n_fail++; $display("FAIL max_npush got=%0d want=%0d", got, MAXT + 1); end
        bad = 0;
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            if (mon_data[base+i] !== exp_q[i]) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL max_data got=%0d bad records want=0", bad); end
        if (got >= 1) begin
            n_checks++; if (mon_data[base+got-1] !== TERM) begin n_fail++; $display("FAIL max_term got=%h want=%h", mon_data[base+got-1], TERM); end
        end
        n_checks++; if (tri_count !== 8'(MAXT)) begin n_fail++; $display("FAIL max_count got=%0d want=%0d", tri_count, MAXT); end
        n_checks++; if (mon_pops - pops0 != MAXT) begin n_fail++; $display("FAIL max_pops got=%0d want=%0d", mon_pops - pops0, MAXT); end
        n_checks++; if (src_head != MAXT) begin n_fail++; $display("FAIL max_head got=%0d want=%0d", src_head, MAXT); end
    endtask

    task automatic test_restart_in_issue();
        int base, pops0, c0, got;
        bit ok;
        load_src(4);
        fifo_wait = 1'b0;
        base = mon_data.size(); pops0 = mon_pops;
        pulse_frame(c0);
        repeat (4) tick();
        nextFrame = 1'b1;
        tick();
        nextFrame = 1'b0;
        n_checks++; if (push !== 1'b0) begin n_fail++; $display("FAIL restart_push got=%b want=0", push); end
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL restart_pop got=%b want=0", pop); end
        n_checks++; if (tri_count !== 8'd0) begin n_fail++; $display("FAIL restart_count got=%0d want=0", tri_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b want=1", busy); end
        wait_idle(100, ok);
        build_model(1);
        got = mon_data.size() - base;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout busy=%b want=0", busy); end
        n_checks++; if (got != exp_q.size() + 1) begin n_fail++; $display("FAIL restart_npush got=%0d want=%0d", got, exp_q.size() + 1); end
        if (got >= 1) begin
            n_checks++; if (mon_data[base] !== src_mem[0]) begin n_fail++; $display("FAIL restart_first got=%h want=%h", mon_data[base], src_mem[0]); end
        end
        for (int i = 0; i + 1 < got && i < exp_q.size(); i++) begin
            n_checks++;
            if (mon_data[base+1+i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_data[%0d] got=%h want=%h", i, mon_data[base+1+i], exp_q[i]); end
        end
        n_checks++; if (tri_count !== 8'(exp_count)) begin n_fail++; $display("FAIL restart_final_count got=%0d want=%0d", tri_count, exp_count); end
        n_checks++; if (mon_pops - pops0 != exp_pops + 1) begin n_fail++; $display("FAIL restart_pops got=%0d want=%0d", mon_pops - pops0, exp_pops + 1); end
    endtask

    task automatic test_reset_mid_frame();
        int base, pops0, c0;
        load_src(4);
        fifo_wait = 1'b0;
        base = mon_data.size(); pops0 = mon_pops;
        pulse_frame(c0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (push !== 1'b0) begin n_fail++; $display("FAIL midrst_push got=%b want=0", push); end
        n_checks++; if (pop !== 1'b0) begin n_fail++; $display("FAIL midrst_pop got=%b want=0", pop); end
        n_checks++; if (wdata !== '0) begin n_fail++; $display("FAIL midrst_wdata got=%h want=0", wdata); end
        n_checks++; if (tri_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got=%0d want=0", tri_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        repeat (10) tick();
        n_checks++; if (mon_data.size() != base) begin n_fail++; $display("FAIL midrst_no_term got=%0d pushes want=0", mon_data.size() - base); end
        n_checks++; if (mon_pops != pops0) begin n_fail++; $display("FAIL midrst_no_pop got=%0d want=0", mon_pops - pops0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got=%b want=0", busy); end
    endtask

    task automatic test_degenerate();
        int base, pops0, c0, got;
        bit ok, seen;
        load_src(3);
        src_mem[1][215:180] = {12'd1280, 12'd1280, 12'd1280};
        fifo_wait = 1'b0;
        base = mon_data.size(); pops0 = mon_pops;
        pulse_frame(c0);
        wait_idle(100, ok);
        build_model(0);
        got = mon_data.size() - base;
        seen = 1'b0;
        for (int i = 0; i < got; i++) if (mon_data[base+i] === src_mem[1]) seen = 1'b1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL degen_timeout busy=%b want=0", busy); end
        n_checks++; if (got != exp_q.size()) begin n_fail++; $display("FAIL degen_npush got=%0d want=%0d", got, exp_q.size()); end
        n_checks++; if (seen != !cull_on()) begin n_fail++; $display("FAIL degen_forwarded got=%b want=%b", seen, !cull_on()); end
        n_checks++; if (tri_count !== (cull_on() ? 8'd2 : 8'd3)) begin n_fail++; $display("FAIL degen_count got=%0d want=%0d", tri_count, cull_on() ? 2 : 3); end
        n_checks++; if (mon_pops - pops0 != 3) begin n_fail++; $display("FAIL degen_pops got=%0d want=3", mon_pops - pops0); end
    endtask

    task automatic test_random_frames();
        int base, pops0, c0, got, n, bad;
        bit ok;
        for (int it = 0; it < 5; it++) begin
            n = (it == 0) ? 0 : int'($urandom_range(1, 12));
            load_src(n);
            base = mon_data.size(); pops0 = mon_pops;
            pulse_frame(c0);
            ok = 1'b0;
            for (int k = 0; k < 400; k++) begin
                fifo_wait = 1'($urandom_range(0, 1));
                if (!busy) begin ok = 1'b1; break; end
                tick();
            end
            fifo_wait = 1'b0;
            tick(); tick();
            build_model(0);
            got = mon_data.size() - base;
            bad = 0;
            for (int i = 0; i < got && i < exp_q.size(); i++) if (mon_data[base+i] !== exp_q[i]) bad++;
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout busy=%b want=0", it, busy); end
            n_checks++; if (got != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_npush got=%0d want=%0d", it, got, exp_q.size()); end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_data got=%0d bad want=0", it, bad); end
            n_checks++; if (tri_count !== 8'(exp_count)) begin n_fail++; $display("FAIL rand%0d_count got=%0d want=%0d", it, tri_count, exp_count); end
            n_checks++; if (mon_pops - pops0 != exp_pops) begin n_fail++; $display("FAIL rand%0d_pops got=%0d want=%0d", it, mon_pops - pops0, exp_pops); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        nextFrame = 1'b0;
        fifo_wait = 1'b0;
        test_reset();
        test_basic_frame();
        test_wait_backpressure();
        test_max_tris();
        test_restart_in_issue();
        test_reset_mid_frame();
        test_degenerate();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vertex_buffer_reader.md
VERTEX_BUFFER_READER -- requirements
Module: vertex_buffer_reader

Interface
REQ-001 SHALL have parameter MAX_TRIS, default 8'd108: the maximum number of records forwarded per frame.
REQ-002 SHALL have port clk100, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port nextFrame, input, 1 bit: a one-cycle pulse that starts a frame.
REQ-005 SHALL have port VertexBuffer_PreCalc_empty, input, 1 bit: the source has no record; it is registered at the source and lags pop by 2 cycles.
REQ-006 SHALL have port VertexBuffer_PreCalc_ReadData, input, 224 bits: the head record (show-ahead).
REQ-007 SHALL have port VertexBuffer_PreCalc_pop, output, 1 bit: a registered one-cycle pulse that advances the source head.
REQ-008 SHALL have port PreCalc_TriangleFIFO_wait, input, 1 bit: back-pressure; the block shall not start a push while it is high.
REQ-009 SHALL have port PreCalc_TriangleFIFO_push, output, 1 bit: registered write strobe.
REQ-010 SHALL have port PreCalc_TriangleFIFO_WriteData, output, 224 bits: registered write data.
REQ-011 SHALL have port tri_count, output, 8 bits: the number of records pushed this frame, excluding the terminator.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.

Function
REQ-013 SHALL implement the states IDLE, FETCH, ISSUE, SETTLE, EOF and DONE.
REQ-014 SHALL go to FETCH from any state on nextFrame; the same edge clears tri_count, push and pop.
REQ-015 In FETCH, if tri_count==MAX_TRIS, the block SHALL go to EOF; this check takes priority.
REQ-016 In FETCH, otherwise, if empty==1 the block SHALL go to EOF.
REQ-017 In FETCH, otherwise, if wait==0 the block SHALL capture ReadData into WriteData and go to ISSUE.
REQ-018 In FETCH, otherwise (wait==1) the block SHALL stay in FETCH.
REQ-019 In ISSUE, the block SHALL assert push=1 and pop=1 for exactly this cycle, increment tri_count, and go to SETTLE.
REQ-020 SETTLE SHALL last one cycle and then go to FETCH; this absorbs the empty/data latency, so peak throughput is one record per 3 cycles.
REQ-021 In EOF, when wait==0, the block SHALL push the terminator {1'b1, 223'b0} for one cycle, without pop, and go to DONE.
REQ-022 In DONE, the block SHALL hold with push=0 and pop=0 until nextFrame.
REQ-023 SHALL forward records unmodified: bits [223:216] are flags, [215:204]/[203:192]/[191:180] are x1/x2/x3, and [179:0] are the remaining fields.
REQ-024 tri_count SHALL saturate at MAX_TRIS and never wrap.
REQ-025 If nextFrame arrives in the same cycle as ISSUE, nextFrame SHALL win: the pending push and pop are suppressed and the record is not counted.
REQ-026 SHALL assert at most one push per record and never assert pop without push (the cull case in REQ-031 excepted).
REQ-027 A wait rising in ISSUE SHALL NOT cancel the push already committed.

Reset
REQ-028 SHALL, when rst_n==0 at a clock edge, set: state=IDLE; push=0; pop=0; WriteData=0; tri_count=0; busy=0.
REQ-029 Reset SHALL override nextFrame, and a reset mid-frame SHALL abandon the frame without a terminator.

Configuration
REQ-030 SHALL support the macro VBR_DEGENERATE_CULL_EN.
REQ-031 With VBR_DEGENERATE_CULL_EN defined, a record where x1==x2==x3 SHALL be popped in ISSUE with push=0 and tri_count unchanged, taking the same 3-cycle cadence.
REQ-032 Without VBR_DEGENERATE_CULL_EN, every record SHALL be forwarded.

Structure
REQ-033 Package vbr_pkg SHALL hold the state enum, the 224-bit record typedef, the field bit-position constants and the terminator constant.
REQ-034 Sub-module vbr_degenerate_detect SHALL be the combinational x1==x2==x3 comparator, instantiated only under VBR_DEGENERATE_CULL_EN.

Verification
REQ-035 The bench SHALL check: source with 3 records, wait=0, nextFrame pulse -> 3 pushes spaced 3 cycles apart, matching ReadData; then terminator 0x8000...0; tri_count=3; DONE; busy=0.
REQ-036 The bench SHALL check: wait=1 for 10 cycles while in FETCH -> no push and no pop; first push at the 2nd edge after wait falls.
REQ-037 The bench SHALL check: source with 200 records, MAX_TRIS=108 -> exactly 108 pushes, then terminator, and the 109th record is never popped.
REQ-038 The bench SHALL check: nextFrame during ISSUE of the 2nd record -> no push that cycle; tri_count=0; restart from FETCH.
REQ-039 The bench SHALL check: rst_n=0 mid-frame for 1 cycle -> all outputs zero at the next edge; no terminator; IDLE until nextFrame.
REQ-040 The bench SHALL check, with VBR_DEGENERATE_CULL_EN: a record with x1=x2=x3=12'd1280 -> pop without push; tri_count unchanged. Without the macro, the same record is pushed.
